// File: rtl/adc_line_buf.sv
// Ping-pong line buffer: ADC samples fill one bank while the MCU reads the other; 1-cycle read latency.
// No backpressure on the ADC side: samples arriving while both banks are owned are dropped and flag OVF.
module adc_line_buf #(
  parameter int NPIX = 112,
  parameter int AW   = 7,
  parameter int LCW  = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [7:0]     DIN,
  input  logic           DVALID,
  input  logic           SOL,
  input  logic [AW-1:0]  RADDR,
  output logic [7:0]     RDATA,
  input  logic           RDONE,
  output logic           LINE_RDY,
  output logic           OVF,
  input  logic           CLR_OVF,
  output logic [LCW-1:0] LINECNT
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_W = (AW+1)'(NPIX);

  state_t        state, state_nxt;
  logic          wbank, rbank;
  logic [AW-1:0] wcnt, wcnt_nxt, wr_idx;
  logic          wr_en, do_swap, ovf_evt;
  logic [AW:0]   wr_addr, rd_addr;
  logic [7:0]    mem [0:2*NPIX-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // SOL restarts the line at index 0, and a DVALID in the same cycle lands there.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    wr_idx    = wcnt;
    wr_en     = 1'b0;
    do_swap   = 1'b0;
    ovf_evt   = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (SOL) begin
          wr_idx    = '0;
          wcnt_nxt  = '0;
          state_nxt = FILL;
        end
        if ((state == FILL || SOL) && DVALID) begin
          wr_en = 1'b1;
          if (wr_idx == LAST) begin
            wcnt_nxt = '0;
            if (!LINE_RDY || RDONE) begin
              do_swap   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD;
            end
          end else begin
            wcnt_nxt = wr_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        ovf_evt = SOL | DVALID;
        if (RDONE) begin
          do_swap   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A swap takes priority over a plain release, so the new line replaces the old one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wbank    <= 1'b0;
      rbank    <= 1'b1;
      LINE_RDY <= 1'b0;
      LINECNT  <= '0;
      OVF      <= 1'b0;
    end else begin
      if (do_swap) begin
        rbank    <= wbank;
        wbank    <= ~wbank;
        LINE_RDY <= 1'b1;
        LINECNT  <= LINECNT + 1'b1;
      end else if (RDONE) begin
        LINE_RDY <= 1'b0;
      end
      if (ovf_evt)
        OVF <= 1'b1;
      else if (CLR_OVF)
        OVF <= 1'b0;
    end
  end

  assign wr_addr = {1'b0, wr_idx} + (wbank ? NPIX_W : '0);
  assign rd_addr = {1'b0, RADDR}  + (rbank ? NPIX_W : '0);

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_addr] <= DIN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      RDATA <= '0;
    else if ({1'b0, RADDR} < NPIX_W)
      RDATA <= mem[rd_addr];
    else
      RDATA <= '0;
  end

endmodule

// File: tb/tb_adc_line_buf.sv
// Bench for adc_line_buf: directed line scenarios plus random traffic against a per-cycle bank model.
module tb_adc_line_buf;
  localparam int NPIX = 112;
  localparam int AW   = 7;
  localparam int LCW  = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [7:0]     DIN;
  logic           DVALID, SOL, RDONE, CLR_OVF;
  logic [AW-1:0]  RADDR;
  logic [7:0]     RDATA;
  logic           LINE_RDY, OVF;
  logic [LCW-1:0] LINECNT;

  always #20 CLK = ~CLK;

  adc_line_buf #(.NPIX(NPIX), .AW(AW), .LCW(LCW)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .DVALID(DVALID), .SOL(SOL),
    .RADDR(RADDR), .RDATA(RDATA), .RDONE(RDONE), .LINE_RDY(LINE_RDY),
    .OVF(OVF), .CLR_OVF(CLR_OVF), .LINECNT(LINECNT)
  );

  // Model: two banks of samples, which bank is being written / held for reading, and line progress.
  logic [7:0]     m_mem   [2][NPIX];
  bit             m_known [2][NPIX];
  bit             m_wb, m_rb, m_lrdy, m_ovf, m_active, m_full;
  int             m_cnt;
  logic [LCW-1:0] m_lcnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_wb = 0; m_rb = 1; m_lrdy = 0; m_ovf = 0; m_active = 0; m_full = 0;
    m_cnt = 0; m_lcnt = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) m_known[b][i] = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    chk("rst_rdata", RDATA, 0);
    chk("rst_line_rdy", LINE_RDY, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_linecnt", LINECNT, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input bit sol, input bit dv, input logic [7:0] din,
                     input bit rdone, input bit clr, input int raddr);
    bit   swap, ovf_set, rd_known;
    logic [7:0] exp_rd;
    SOL = sol; DVALID = dv; DIN = din; RDONE = rdone; CLR_OVF = clr;
    RADDR = raddr[AW-1:0];
    if (raddr >= NPIX) begin
      rd_known = 1; exp_rd = 8'h00;
    end else begin
      rd_known = m_known[m_rb][raddr]; exp_rd = m_mem[m_rb][raddr];
    end
    @(posedge CLK);
    swap = 0; ovf_set = 0;
    if (m_full) begin
      if (sol || dv) ovf_set = 1;
      if (rdone) swap = 1;
    end else if (m_active || sol) begin
      m_active = 1;
      if (sol) m_cnt = 0;
      if (dv) begin
        m_mem[m_wb][m_cnt] = din;
        m_known[m_wb][m_cnt] = 1;
        if (m_cnt == NPIX - 1) begin
          m_active = 0; m_cnt = 0;
          if (!m_lrdy || rdone) swap = 1;
          else m_full = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    if (swap) begin
      m_rb = m_wb; m_wb = !m_wb; m_lrdy = 1; m_lcnt = m_lcnt + 1'b1;
      m_full = 0; m_active = 0;
    end else if (rdone) begin
      m_lrdy = 0;
    end
    if (ovf_set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    #1;
    chk("line_rdy", LINE_RDY, m_lrdy);
    chk("ovf", OVF, m_ovf);
    chk("linecnt", LINECNT, m_lcnt);
    if (rd_known) chk("rdata", RDATA, exp_rd);
  endtask

  task automatic fill_line(input logic [7:0] val, input bit use_index, input bit sol_with_first);
    if (!sol_with_first) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++)
      cyc(sol_with_first && i == 0, 1, use_index ? i[7:0] : val, 0, 0, 0);
  endtask

  initial begin
    SOL = 0; DVALID = 0; DIN = 0; RDONE = 0; CLR_OVF = 0; RADDR = '0; RESET = 0;
    do_reset();

    // Line of DIN=index, then read it back including out-of-range addresses.
    fill_line(0, 1, 0);
    chk("s1_line_rdy", LINE_RDY, 1);
    chk("s1_linecnt", LINECNT, 1);
    for (int i = 0; i < 128; i++) cyc(0, 0, 0, 0, 0, i);
    cyc(0, 0, 0, 0, 0, 37);
    chk("s1_rdata37", RDATA, 37);

    // Second line while the first is held: HOLD, overflow, then release swaps.
    fill_line(8'hA5, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h5A, 0, 0, 5);
    chk("s2_ovf", OVF, 1);
    chk("s2_rdata_old", RDATA, 5);
    chk("s2_linecnt_hold", LINECNT, 1);
    cyc(0, 0, 0, 1, 0, 9);
    chk("s2_line_rdy", LINE_RDY, 1);
    chk("s2_linecnt", LINECNT, 2);
    cyc(0, 0, 0, 0, 0, 9);
    chk("s2_rdata_new", RDATA, 8'hA5);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s2_ovf_clr", OVF, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("s2_release", LINE_RDY, 0);

    // Partial line discarded by a new SOL.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 1, 8'h11, 0, 0, 0);
    fill_line(8'h3C, 0, 0);
    chk("s3_linecnt", LINECNT, 1);
    for (int i = 0; i < NPIX; i++) begin
      cyc(0, 0, 0, 0, 0, i);
      chk("s3_rdata", RDATA, 8'h3C);
    end

    // Release in the same cycle as the last write of line 2.
    do_reset();
    fill_line(0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX - 1; i++) cyc(0, 1, 8'h77, 0, 0, 0);
    cyc(0, 1, 8'h77, 1, 0, 3);
    chk("s4_line_rdy", LINE_RDY, 1);
    chk("s4_ovf", OVF, 0);
    chk("s4_linecnt", LINECNT, 2);
    cyc(0, 0, 0, 0, 0, 3);
    chk("s4_rdata", RDATA, 8'h77);

    // Reset mid-line, then a normal line.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(0, 1, 8'h99, 0, 0, 0);
    do_reset();
    fill_line(8'h42, 0, 0);
    chk("s5_linecnt", LINECNT, 1);
    chk("s5_line_rdy", LINE_RDY, 1);

    // Overflow set beats a simultaneous clear.
    fill_line(8'h24, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("s6_ovf_set", OVF, 1);
    cyc(0, 1, 0, 0, 1, 0);
    chk("s6_set_wins", OVF, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s6_clear", OVF, 0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 65, 8'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2, $urandom_range(0, 127));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
